// File: rtl/cl_axi_rd_arbiter_2_to_1.sv
// Two-to-one round-robin AXI4 read arbiter: registers the winning AR, tags ARID with
// the source port, routes R beats back by that tag and caps outstanding bursts per port.
module cl_axi_rd_arbiter_2_to_1 #(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 512,
  parameter int ID_W    = 16,
  parameter int SID_W   = 7,
  parameter int MAX_OUT = 8
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic              s0_arvalid,
  output logic              s0_arready,
  input  logic [ADDR_W-1:0] s0_araddr,
  input  logic [7:0]        s0_arlen,
  input  logic [2:0]        s0_arsize,
  input  logic [1:0]        s0_arburst,
  input  logic [ID_W-1:0]   s0_arid,
  output logic              s0_rvalid,
  input  logic              s0_rready,
  output logic [DATA_W-1:0] s0_rdata,
  output logic [1:0]        s0_rresp,
  output logic              s0_rlast,
  output logic [ID_W-1:0]   s0_rid,
  input  logic              s1_arvalid,
  output logic              s1_arready,
  input  logic [ADDR_W-1:0] s1_araddr,
  input  logic [7:0]        s1_arlen,
  input  logic [2:0]        s1_arsize,
  input  logic [1:0]        s1_arburst,
  input  logic [ID_W-1:0]   s1_arid,
  output logic              s1_rvalid,
  input  logic              s1_rready,
  output logic [DATA_W-1:0] s1_rdata,
  output logic [1:0]        s1_rresp,
  output logic              s1_rlast,
  output logic [ID_W-1:0]   s1_rid,
  output logic              m_arvalid,
  input  logic              m_arready,
  output logic [ADDR_W-1:0] m_araddr,
  output logic [7:0]        m_arlen,
  output logic [2:0]        m_arsize,
  output logic [1:0]        m_arburst,
  output logic [ID_W-1:0]   m_arid,
  input  logic              m_rvalid,
  output logic              m_rready,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic [1:0]        m_rresp,
  input  logic              m_rlast,
  input  logic [ID_W-1:0]   m_rid,
  output logic              busy,
  output logic              dbg_state,
  output logic              dbg_rr_ptr,
  output logic [7:0]        dbg_cnt_0,
  output logic [7:0]        dbg_cnt_1
);

  // Handshakes: a transfer happens on a rising aclk edge where valid and ready are both 1;
  // valid never waits on ready, except s*_arready which may follow s*_arvalid combinationally.

  typedef enum logic {IDLE = 1'b0, PEND = 1'b1} state_t;

  localparam logic [7:0] MAX_CNT = 8'(MAX_OUT);

  state_t     state;
  logic       rr_ptr;
  logic [7:0] cnt_0, cnt_1;

  logic       elig_0, elig_1, grant_0, grant_1;
  logic       sel, dec_0, dec_1;
  logic [7:0] cnt_0_n, cnt_1_n;
  state_t     state_n;
  logic [ID_W-1:0] arid_n;

  function automatic logic [7:0] cnt_next(input logic [7:0] c, input logic inc,
                                          input logic dec);
    logic [7:0] r;
    r = c;
    if (inc && !dec) r = c + 8'd1;
    else if (dec && !inc && c != 8'd0) r = c - 8'd1;
    return r;
  endfunction

  always_comb begin
    elig_0  = s0_arvalid && (cnt_0 < MAX_CNT);
    elig_1  = s1_arvalid && (cnt_1 < MAX_CNT);
    grant_0 = !areset && (state == IDLE) && elig_0 && (!elig_1 || !rr_ptr);
    grant_1 = !areset && (state == IDLE) && elig_1 && (!elig_0 || rr_ptr);
    s0_arready = grant_0;
    s1_arready = grant_1;

    arid_n = '0;
    arid_n[SID_W] = grant_1;
    arid_n[SID_W-1:0] = grant_1 ? s1_arid[SID_W-1:0] : s0_arid[SID_W-1:0];
  end

  // R path is a pure pass-through steered by the source tag in m_rid.
  always_comb begin
    sel       = m_rid[SID_W];
    s0_rvalid = !areset && m_rvalid && !sel;
    s1_rvalid = !areset && m_rvalid && sel;
    m_rready  = !areset && (sel ? s1_rready : s0_rready);
    s0_rdata  = m_rdata;
    s1_rdata  = m_rdata;
    s0_rresp  = m_rresp;
    s1_rresp  = m_rresp;
    s0_rlast  = m_rlast;
    s1_rlast  = m_rlast;
    s0_rid    = '0;
    s0_rid[SID_W-1:0] = m_rid[SID_W-1:0];
    s1_rid    = s0_rid;
    dec_0     = m_rvalid && m_rready && m_rlast && !sel;
    dec_1     = m_rvalid && m_rready && m_rlast && sel;
  end

  always_comb begin
    cnt_0_n = cnt_next(cnt_0, grant_0, dec_0);
    cnt_1_n = cnt_next(cnt_1, grant_1, dec_1);
    state_n = state;
    if (state == IDLE && (grant_0 || grant_1)) state_n = PEND;
    else if (state == PEND && m_arready) state_n = IDLE;
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state     <= IDLE;
      m_arvalid <= 1'b0;
      m_araddr  <= '0;
      m_arlen   <= '0;
      m_arsize  <= '0;
      m_arburst <= '0;
      m_arid    <= '0;
      rr_ptr    <= 1'b0;
      cnt_0     <= '0;
      cnt_1     <= '0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      m_arvalid <= (state_n == PEND);
      cnt_0     <= cnt_0_n;
      cnt_1     <= cnt_1_n;
      busy      <= (state_n == PEND) || (cnt_0_n != 8'd0) || (cnt_1_n != 8'd0);
      if (grant_0 || grant_1) begin
        m_araddr  <= grant_1 ? s1_araddr  : s0_araddr;
        m_arlen   <= grant_1 ? s1_arlen   : s0_arlen;
        m_arsize  <= grant_1 ? s1_arsize  : s0_arsize;
        m_arburst <= grant_1 ? s1_arburst : s0_arburst;
        m_arid    <= arid_n;
        rr_ptr    <= !grant_1;
      end
    end
  end

  assign dbg_state  = state;
  assign dbg_rr_ptr = rr_ptr;
  assign dbg_cnt_0  = cnt_0;
  assign dbg_cnt_1  = cnt_1;

endmodule

// File: tb/tb_cl_axi_rd_arbiter_2_to_1.sv
// Directed bench for cl_axi_rd_arbiter_2_to_1 built with MAX_OUT=3 so the cap and
// a count of 3 at reset can both be exercised on one instance.
module tb_cl_axi_rd_arbiter_2_to_1;
  localparam int ADDR_W = 64, DATA_W = 512, ID_W = 16, SID_W = 7, MAX_OUT = 3;

  logic aclk = 1'b0, areset = 1'b1;
  logic s0_arvalid = 0, s0_arready, s0_rvalid, s0_rready = 0, s0_rlast;
  logic [ADDR_W-1:0] s0_araddr = '0;
  logic [7:0] s0_arlen = '0;
  logic [2:0] s0_arsize = 3'd6;
  logic [1:0] s0_arburst = 2'd1, s0_rresp;
  logic [ID_W-1:0] s0_arid = '0, s0_rid;
  logic [DATA_W-1:0] s0_rdata;
  logic s1_arvalid = 0, s1_arready, s1_rvalid, s1_rready = 0, s1_rlast;
  logic [ADDR_W-1:0] s1_araddr = '0;
  logic [7:0] s1_arlen = '0;
  logic [2:0] s1_arsize = 3'd6;
  logic [1:0] s1_arburst = 2'd1, s1_rresp;
  logic [ID_W-1:0] s1_arid = '0, s1_rid;
  logic [DATA_W-1:0] s1_rdata;
  logic m_arvalid, m_arready = 0, m_rvalid = 0, m_rready, m_rlast = 0;
  logic [ADDR_W-1:0] m_araddr;
  logic [7:0] m_arlen;
  logic [2:0] m_arsize;
  logic [1:0] m_arburst, m_rresp = 2'd0;
  logic [ID_W-1:0] m_arid, m_rid = '0;
  logic [DATA_W-1:0] m_rdata = '0;
  logic busy, dbg_state, dbg_rr_ptr;
  logic [7:0] dbg_cnt_0, dbg_cnt_1;

  int checks = 0, failures = 0;
  logic [DATA_W-1:0] exp_q[$];

  cl_axi_rd_arbiter_2_to_1 #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W),
                             .SID_W(SID_W), .MAX_OUT(MAX_OUT)) dut (
    .aclk(aclk), .areset(areset),
    .s0_arvalid(s0_arvalid), .s0_arready(s0_arready), .s0_araddr(s0_araddr),
    .s0_arlen(s0_arlen), .s0_arsize(s0_arsize), .s0_arburst(s0_arburst), .s0_arid(s0_arid),
    .s0_rvalid(s0_rvalid), .s0_rready(s0_rready), .s0_rdata(s0_rdata), .s0_rresp(s0_rresp),
    .s0_rlast(s0_rlast), .s0_rid(s0_rid),
    .s1_arvalid(s1_arvalid), .s1_arready(s1_arready), .s1_araddr(s1_araddr),
    .s1_arlen(s1_arlen), .s1_arsize(s1_arsize), .s1_arburst(s1_arburst), .s1_arid(s1_arid),
    .s1_rvalid(s1_rvalid), .s1_rready(s1_rready), .s1_rdata(s1_rdata), .s1_rresp(s1_rresp),
    .s1_rlast(s1_rlast), .s1_rid(s1_rid),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arlen(m_arlen),
    .m_arsize(m_arsize), .m_arburst(m_arburst), .m_arid(m_arid),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp),
    .m_rlast(m_rlast), .m_rid(m_rid),
    .busy(busy), .dbg_state(dbg_state), .dbg_rr_ptr(dbg_rr_ptr),
    .dbg_cnt_0(dbg_cnt_0), .dbg_cnt_1(dbg_cnt_1)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs,
                     input logic [DATA_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1ns later, well before the rising edge.
  task automatic step();
    @(posedge aclk);
    @(negedge aclk);
  endtask

  task automatic r_beat(input logic [ID_W-1:0] rid, input logic last,
                        input logic rdy0, input logic rdy1);
    logic [DATA_W-1:0] d;
    logic s;
    d = {16{$urandom()}};
    s = rid[SID_W];
    m_rvalid = 1'b1; m_rid = rid; m_rlast = last; m_rdata = d;
    s0_rready = rdy0; s1_rready = rdy1;
    exp_q.push_back(d);
    #1;
    chk("r_s0_rvalid", s0_rvalid, !s);
    chk("r_s1_rvalid", s1_rvalid, s);
    chk("r_m_rready", m_rready, s ? rdy1 : rdy0);
    chk("r_rdata", s ? s1_rdata : s0_rdata, exp_q.pop_front());
    chk("r_rid", s ? s1_rid : s0_rid, {9'd0, rid[SID_W-1:0]});
    chk("r_rlast", s ? s1_rlast : s0_rlast, last);
  endtask

  task automatic r_idle();
    m_rvalid = 1'b0; m_rlast = 1'b0; s0_rready = 1'b0; s1_rready = 1'b0;
  endtask

  initial begin
    // Reset: ready/valid outputs forced low even with live inputs.
    @(negedge aclk);
    s0_arvalid = 1; s1_arvalid = 1; m_rvalid = 1; s0_rready = 1;
    #1;
    chk("rst_s0_arready", s0_arready, 0);
    chk("rst_s1_arready", s1_arready, 0);
    chk("rst_s0_rvalid", s0_rvalid, 0);
    chk("rst_m_rready", m_rready, 0);
    step();
    s0_arvalid = 0; s1_arvalid = 0; r_idle(); areset = 0;
    #1;
    chk("rst_m_arvalid", m_arvalid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cnt_0", dbg_cnt_0, 0);
    chk("rst_state", dbg_state, 0);

    // Single request on port 0 followed by a 4-beat burst.
    step();
    s0_arvalid = 1; s0_araddr = 64'h1000; s0_arlen = 8'd3; s0_arid = 16'h0005;
    #1;
    chk("t1_s0_arready", s0_arready, 1);
    chk("t1_s1_arready", s1_arready, 0);
    step();
    s0_arvalid = 0;
    #1;
    chk("t1_m_arvalid", m_arvalid, 1);
    chk("t1_m_araddr", m_araddr, 64'h1000);
    chk("t1_m_arlen", m_arlen, 3);
    chk("t1_m_arid", m_arid, 16'h0005);
    chk("t1_cnt_0", dbg_cnt_0, 1);
    chk("t1_busy", busy, 1);
    m_arready = 1;
    step();
    m_arready = 0;
    for (int b = 0; b < 4; b++) begin
      r_beat(16'h0005, b == 3, 1'b1, 1'b0);
      step();
      if (b < 3) chk("t1_cnt_mid", dbg_cnt_0, 1);
    end
    r_idle();
    #1;
    chk("t1_cnt_end", dbg_cnt_0, 0);
    chk("t1_busy_end", busy, 0);

    // Contention: rr_ptr points at port 1 after the port-0 grant, so 1,0,1,0.
    s0_arvalid = 1; s1_arvalid = 1; m_arready = 1;
    s0_arid = 16'h0011; s1_arid = 16'h0022;
    for (int g = 0; g < 4; g++) begin
      #1;
      chk("t2_s0_arready", s0_arready, g[0]);
      chk("t2_s1_arready", s1_arready, !g[0]);
      step();
      #1;
      chk("t2_m_arvalid", m_arvalid, 1);
      chk("t2_pend_ready", {s0_arready, s1_arready}, 2'b00);
      chk("t2_m_arid", m_arid, g[0] ? 16'h0011 : 16'h00A2);
      step();
    end
    s0_arvalid = 0; s1_arvalid = 0;
    #1;
    chk("t2_cnt_0", dbg_cnt_0, 2);
    chk("t2_cnt_1", dbg_cnt_1, 2);

    // Cap: fill both ports to 3, then release one at a time.
    s0_arvalid = 1; step(); s0_arvalid = 0; step();
    s1_arvalid = 1; step(); s1_arvalid = 0; step();
    #1;
    chk("t3_cnt_0", dbg_cnt_0, 3);
    chk("t3_cnt_1", dbg_cnt_1, 3);
    s0_arvalid = 1; s1_arvalid = 1;
    #1;
    chk("t3_capped", {s0_arready, s1_arready}, 2'b00);
    step();
    r_beat(16'h0080, 1'b1, 1'b0, 1'b1);
    chk("t3_still_capped", {s0_arready, s1_arready}, 2'b00);
    step();
    r_idle();
    #1;
    chk("t3_s1_regrant", {s0_arready, s1_arready}, 2'b01);
    step(); step();
    r_beat(16'h0000, 1'b1, 1'b1, 1'b0);
    chk("t3_s0_blocked", s0_arready, 0);
    step();
    r_idle();
    #1;
    chk("t3_s0_regrant", {s0_arready, s1_arready}, 2'b10);
    step();
    s0_arvalid = 0; s1_arvalid = 0;
    step();

    // Same-cycle AR grant and rlast on port 1 with cnt_1 at 1.
    r_beat(16'h0080, 1'b1, 1'b0, 1'b1); step();
    r_beat(16'h0080, 1'b1, 1'b0, 1'b1); step();
    r_idle();
    #1;
    chk("t4_cnt_1_pre", dbg_cnt_1, 1);
    s1_arvalid = 1;
    r_beat(16'h0080, 1'b1, 1'b0, 1'b1);
    chk("t4_s1_arready", s1_arready, 1);
    step();
    r_idle(); s1_arvalid = 0;
    #1;
    chk("t4_cnt_1", dbg_cnt_1, 1);
    step();

    // Backpressure in PEND; upper arid bits ignored, tag forced to 1.
    m_arready = 0;
    s1_arvalid = 1; s1_araddr = 64'hABCD_0040; s1_arid = 16'hFF7F;
    step();
    s0_arvalid = 1;
    for (int c = 0; c < 5; c++) begin
      if (c == 2) r_beat(16'h0083, 1'b1, 1'b1, 1'b0);
      #1;
      chk("t5_m_arvalid", m_arvalid, 1);
      chk("t5_m_araddr", m_araddr, 64'hABCD_0040);
      chk("t5_m_arid", m_arid, 16'h00FF);
      chk("t5_ready", {s0_arready, s1_arready}, 2'b00);
      step();
      r_idle();
    end
    chk("t5_cnt_1", dbg_cnt_1, 2);
    s0_arvalid = 0;
    m_arready = 1; step(); s1_arvalid = 0; step();
    m_arready = 0;

    // Reset while PEND with cnt_0=3.
    s1_arvalid = 1; step(); s1_arvalid = 0;
    #1;
    chk("t6_pre_state", dbg_state, 1);
    chk("t6_pre_cnt_0", dbg_cnt_0, 3);
    areset = 1; m_rvalid = 1; s0_rready = 1;
    #1;
    chk("t6_rst_rvalid", s0_rvalid, 0);
    step();
    areset = 0; r_idle();
    #1;
    chk("t6_m_arvalid", m_arvalid, 0);
    chk("t6_cnts", {dbg_cnt_0, dbg_cnt_1}, 16'd0);
    chk("t6_busy", busy, 0);
    chk("t6_rr_ptr", dbg_rr_ptr, 0);
    r_beat(16'h0000, 1'b1, 1'b1, 1'b0);
    step();
    r_idle();
    #1;
    chk("t6_stray_cnt", dbg_cnt_0, 0);
    chk("t6_stray_busy", busy, 0);
    s0_arvalid = 1; s1_arvalid = 1;
    #1;
    chk("t6_tie", {s0_arready, s1_arready}, 2'b10);
    step();
    s0_arvalid = 0; s1_arvalid = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end
endmodule
